// File: rtl/dff_deser_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dff_deser_if : serial-in / word-out bus for the dff_deser deserializer
// Revision     : 1.0
// ---------------------------------------------------------------------------
interface dff_deser_if #(
  parameter int WIDTH = 8
);
  localparam int c_CNT_W = $clog2(WIDTH);

  logic               din;
  logic               din_valid;
  logic               sync;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic [c_CNT_W-1:0] bit_cnt;
  logic               overflow;
  logic [7:0]         drop_cnt;

  modport master (
    output din, din_valid, sync, out_ready,
    input  out_data, out_valid, bit_cnt, overflow, drop_cnt
  );

  modport slave (
    input  din, din_valid, sync, out_ready,
    output out_data, out_valid, bit_cnt, overflow, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/dff_deser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dff_deser : serial-to-parallel deserializer with a one-word output holding
//             register, frame resync and a saturating dropped-word counter
// Revision  : 1.0
// ---------------------------------------------------------------------------
module dff_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  dff_deser_if.slave  bus
);
  localparam int                 c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_out_data;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic               r_overflow;
  logic [7:0]         r_drop_cnt;

  logic [WIDTH-1:0]   w_shifted;
  logic               w_complete;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_shift[WIDTH-2:0], bus.din};
    end else begin : g_lsb_first
      assign w_shifted = {bus.din, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // sync outranks a coincident final bit, so it suppresses completion
  assign w_complete = bus.din_valid && !bus.sync && (r_bit_cnt == c_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= EMPTY;
      r_shift    <= '0;
      r_out_data <= '0;
      r_bit_cnt  <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_overflow <= 1'b0;

      if (bus.sync) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (bus.din_valid) begin
        if (w_complete) begin
          r_shift   <= '0;
          r_bit_cnt <= '0;
        end else begin
          r_shift   <= w_shifted;
          r_bit_cnt <= r_bit_cnt + c_ONE;
        end
      end

      case (r_state)
        EMPTY: begin
          if (w_complete) begin
            r_out_data <= w_shifted;
            r_state    <= FULL;
          end
        end
        FULL: begin
          if (bus.out_ready) begin
            if (w_complete) begin
              r_out_data <= w_shifted;
            end else begin
              r_state <= EMPTY;
            end
          end else if (w_complete) begin
            // held word wins; the new one is lost and counted
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
              r_drop_cnt <= r_drop_cnt + 8'd1;
            end
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = (r_state == FULL);
  assign bus.bit_cnt   = r_bit_cnt;
  assign bus.overflow  = r_overflow;
  assign bus.drop_cnt  = r_drop_cnt;
endmodule
`default_nettype wire

// File: tb/tb_dff_deser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dff_deser : scoreboard bench driving MSB-first and LSB-first instances
// Revision     : 1.0
// ---------------------------------------------------------------------------
module tb_dff_deser;
  localparam int W = 8;

  logic clk       = 1'b0;
  logic rst       = 1'b0;
  logic din       = 1'b0;
  logic din_valid = 1'b0;
  logic sync      = 1'b0;
  logic out_ready = 1'b0;

  always #5 clk = ~clk;

  dff_deser_if #(.WIDTH(W)) if_m ();
  dff_deser_if #(.WIDTH(W)) if_l ();

  assign if_m.din       = din;
  assign if_m.din_valid = din_valid;
  assign if_m.sync      = sync;
  assign if_m.out_ready = out_ready;
  assign if_l.din       = din;
  assign if_l.din_valid = din_valid;
  assign if_l.sync      = sync;
  assign if_l.out_ready = out_ready;

  dff_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(if_m.slave));
  dff_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(if_l.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bit list, holding-slot occupancy, drop count.
  // Expected words are queued as {msb_first_word, lsb_first_word}.
  bit          bits_q[$];
  bit          m_full = 1'b0;
  bit          m_ovf  = 1'b0;
  int          m_drops = 0;
  logic [15:0] exp_q[$];

  always @(posedge clk) begin : p_model
    bit done;
    int am;
    int al;
    #1;
    if (!rst) begin
      bits_q.delete();
      exp_q.delete();
      m_full  = 1'b0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      done  = 1'b0;
      m_ovf = 1'b0;
      am    = 0;
      al    = 0;
      if (sync) begin
        bits_q.delete();
      end else if (din_valid) begin
        bits_q.push_back(din);
        if (bits_q.size() == W) begin
          for (int i = 0; i < W; i++) begin
            am = am + (int'(bits_q[i]) << (W - 1 - i));
            al = al + (int'(bits_q[i]) << i);
          end
          bits_q.delete();
          done = 1'b1;
        end
      end
      if (m_full && out_ready) m_full = 1'b0;
      if (done) begin
        if (!m_full) begin
          m_full = 1'b1;
          exp_q.push_back({8'(am), 8'(al)});
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
  end

  // Monitor: pops the next expected word whenever the DUT presents a new one.
  bit          pv  = 1'b0;
  logic [15:0] cur = 16'h0;

  always @(posedge clk) begin : p_mon
    bit hs;
    #2;
    if (!rst) begin
      chk("rst_valid", {if_m.out_valid, if_l.out_valid}, 32'd0);
      chk("rst_data",  {if_m.out_data, if_l.out_data}, 32'd0);
      chk("rst_bitcnt", {if_m.bit_cnt, if_l.bit_cnt}, 32'd0);
      chk("rst_ovf",   {if_m.overflow, if_l.overflow}, 32'd0);
      chk("rst_drop",  {if_m.drop_cnt, if_l.drop_cnt}, 32'd0);
      pv = 1'b0;
    end else begin
      hs = pv && out_ready;
      if (if_m.out_valid && (!pv || hs)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h expected none at %0t", if_m.out_data, $time);
        end else begin
          cur = exp_q.pop_front();
        end
      end
      if (if_m.out_valid) chk("data_msb", {24'd0, if_m.out_data}, {24'd0, cur[15:8]});
      if (if_l.out_valid) chk("data_lsb", {24'd0, if_l.out_data}, {24'd0, cur[7:0]});
      chk("out_valid", {if_m.out_valid, if_l.out_valid}, {30'd0, {2{m_full}}});
      chk("overflow",  {if_m.overflow, if_l.overflow}, {30'd0, {2{m_ovf}}});
      chk("drop_cnt",  {if_m.drop_cnt, if_l.drop_cnt}, {16'd0, {2{8'(m_drops)}}});
      chk("bit_cnt",   {if_m.bit_cnt, if_l.bit_cnt}, {26'd0, {2{3'(bits_q.size())}}});
      pv = if_m.out_valid;
    end
  end

  task automatic cyc(input logic b, input logic v, input logic s, input logic r);
    din       = b;
    din_valid = v;
    sync      = s;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w, input logic r, input int gap);
    for (int i = 7; i >= 0; i--) begin
      cyc(w[i], 1'b1, 1'b0, r);
      if (i != 0) repeat (gap) cyc(1'b0, 1'b0, 1'b0, r);
    end
  endtask

  initial begin : p_stim
    logic [7:0] w22;
    w22 = 8'h22;
    repeat (3) @(negedge clk);
    chk("reset_state", {if_m.out_valid, if_m.out_data, if_m.drop_cnt}, 32'd0);
    rst = 1'b1;

    // 0xB2 back-to-back, consumer always ready
    send_word(8'hB2, 1'b1, 0);
    chk("b2_valid", {31'd0, if_m.out_valid}, 32'd1);
    chk("b2_msb", {24'd0, if_m.out_data}, 32'hB2);
    chk("b2_lsb", {24'd0, if_l.out_data}, 32'h4D);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2_one_cycle", {31'd0, if_m.out_valid}, 32'd0);

    // same bits with 3 idle cycles between valid bits
    send_word(8'hB2, 1'b1, 3);
    chk("gap_lsb", {24'd0, if_l.out_data}, 32'h4D);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // back-pressure: two of three words dropped
    send_word(8'hA5, 1'b0, 0);
    send_word(8'h3C, 1'b0, 0);
    send_word(8'hFF, 1'b0, 0);
    chk("bp_hold", {24'd0, if_m.out_data}, 32'hA5);
    chk("bp_drops", {24'd0, if_m.drop_cnt}, 32'd2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_drained", {31'd0, if_m.out_valid}, 32'd0);

    // consume and reload on the same edge
    send_word(8'h11, 1'b0, 0);
    for (int i = 7; i >= 1; i--) cyc(w22[i], 1'b1, 1'b0, 1'b0);
    cyc(w22[0], 1'b1, 1'b0, 1'b1);
    out_ready = 1'b0;
    chk("reload_data", {24'd0, if_m.out_data}, 32'h22);
    chk("reload_valid_ovf", {30'd0, if_m.out_valid, if_m.overflow}, 32'd2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // sync mid-word, then a clean word; then sync on the final bit
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("sync_clear", {29'd0, if_m.bit_cnt}, 32'd0);
    send_word(8'h81, 1'b1, 0);
    chk("sync_word", {24'd0, if_m.out_data}, 32'h81);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (7) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("sync_last_bit", {28'd0, if_m.out_valid, if_m.bit_cnt}, 32'd0);

    // asynchronous reset while FULL with a partial word
    send_word(8'h5A, 1'b0, 0);
    repeat (5) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst", {if_m.out_valid, if_m.out_data, if_m.bit_cnt, if_l.out_data}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send_word(8'hC3, 1'b1, 0);
    chk("post_rst", {24'd0, if_m.out_data}, 32'hC3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // randomized traffic
    repeat (2000) begin
      cyc(1'($urandom), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 29) == 0),
          1'($urandom_range(0, 1)));
    end

    // drop counter saturation
    repeat (260 * W) cyc(1'($urandom), 1'b1, 1'b0, 1'b0);
    chk("drop_sat", {if_m.drop_cnt, if_l.drop_cnt}, 32'hFFFF);

    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("final_empty", {31'd0, if_m.out_valid}, 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dff_deser.md
DFF_DESER -- requirements
Module: dff_deser

Interface
REQ-001 Parameter WIDTH, default 8, meaning deserialized word width in bits (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1, meaning first received bit lands in out_data[WIDTH-1] (1) or out_data[0] (0).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; assertion (0) clears state immediately, deassertion is synchronous to clk.
REQ-005 din  input  1  serial bit, the registered dout of the upstream dff stage.
REQ-006 din_valid  input  1  din carries a valid bit this cycle.
REQ-007 sync  input  1  frame restart; discards any partial word.
REQ-008 out_data  output  WIDTH  assembled word; meaningful only while out_valid=1.
REQ-009 out_valid  output  1  out_data holds an unconsumed word.
REQ-010 out_ready  input  1  consumer accepts out_data when out_valid & out_ready at a rising edge.
REQ-011 bit_cnt  output  clog2(WIDTH)  number of bits held in the partial word.
REQ-012 overflow  output  1  one-cycle pulse when a completed word is dropped.
REQ-013 drop_cnt  output  8  count of dropped words; saturates at 255.

Function
REQ-014 Each cycle with din_valid=1 and sync=0 shall shift din into the shift register and increment bit_cnt.
REQ-015 Cycles with din_valid=0 shall hold the shift register and bit_cnt unchanged.
REQ-016 With MSB_FIRST=1, the word shall be left-shifted and the first bit shall end in bit WIDTH-1; with MSB_FIRST=0, it shall be right-shifted and the first bit shall end in bit 0.
REQ-017 The word shall complete on the edge that accepts the WIDTH-th bit: bit_cnt wraps to 0 on that edge, and the word shall appear on out_data with out_valid=1 the following cycle (latency 1 clk after the last bit).
REQ-018 The output register FSM shall have two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 EMPTY->FULL on word completion; FULL->EMPTY on out_ready=1 with no completion; FULL->FULL, with out_data reloaded, on out_ready=1 and a completion in the same cycle, with no overflow.
REQ-020 FULL with out_ready=0 and a completion shall keep the old out_data, drop the new word, pulse overflow for exactly 1 cycle and increment drop_cnt, except that drop_cnt shall hold at 255.
REQ-021 out_data and out_valid shall stay stable while out_valid=1 and out_ready=0.
REQ-022 sync=1 shall clear bit_cnt and the shift register, and the din sampled in that cycle shall be discarded regardless of din_valid.
REQ-023 sync=1 shall not affect the output register, out_valid or drop_cnt.
REQ-024 When sync=1 coincides with the WIDTH-th bit, sync shall win: no word completes and no overflow occurs.
REQ-025 out_ready while EMPTY shall be ignored.
REQ-026 out_data shall not change in EMPTY except on load.

Reset
REQ-027 While rst=0: out_data=0, out_valid=0, bit_cnt=0, shift register=0, overflow=0, drop_cnt=0, FSM=EMPTY.
REQ-028 Reset asserted mid-word or while FULL shall discard all partial and held data with no overflow pulse.
REQ-029 The first edge after rst deassertion shall be able to accept a bit.

Verification
REQ-030 WIDTH=8, MSB_FIRST=1, out_ready=1, bits 1,0,1,1,0,0,1,0 on 8 consecutive valid cycles -> out_valid=1 for 1 cycle with out_data=0xB2, one cycle after the 8th bit.
REQ-031 MSB_FIRST=0, same bits -> out_data=0x4D; the same bits with din_valid gaps of 3 idle cycles -> identical word, later by exactly the gap count.
REQ-032 out_ready=0, stream 24 bits (0xA5, 0x3C, 0xFF) -> out_data stays 0xA5, overflow pulses twice, drop_cnt=2; then out_ready=1 -> one handshake, then out_valid=0.
REQ-033 FULL with 0x11, out_ready=1 on the same edge that completes 0x22 -> 0x11 consumed, out_data=0x22, out_valid stays 1, overflow=0.
REQ-034 5 bits, then sync=1, then 8 bits of 0x81 -> out_data=0x81, no stale bits; sync on the 8th bit -> no word, bit_cnt=0.
REQ-035 rst=0 asynchronously at bit_cnt=5 while FULL -> all outputs 0 before the next edge; after release, 0xC3 is received correctly.
